elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Collects hall calls (per-floor up/down buttons) and car calls (in-cabin floor buttons) into pending bitmaps.
- Runs a collective SCAN policy (IDLE / UP / DOWN) that presents one registered target floor at a time to the elevator motion controller.
- Clears served calls when the door-open rising edge is seen at a floor.
- Sits between the button panels and the target-floor input of the elevator motion/door block, replacing the fixed two-passenger sequencing.

Parameters:
- NUM_FLOORS, 8, number of floors served (floor indices 0..NUM_FLOORS-1).
- FLOOR_W, 3, width of floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- hall_up_req  input  NUM_FLOORS  level/pulse up-call per floor; bit NUM_FLOORS-1 ignored.
- hall_dn_req  input  NUM_FLOORS  level/pulse down-call per floor; bit 0 ignored.
- car_req  input  NUM_FLOORS  in-cabin floor button per floor.
- ev_floor  input  FLOOR_W  current car floor from motion block.
- ev_door  input  1  door status from motion block (1 = open).
- target_floor  output  FLOOR_W  floor the car must travel to.
- target_valid  output  1  target_floor holds a pending call.
- ev_dir  output  2  scan direction: 01 up, 10 down, 00 idle (same encoding as motion block updown).
- pend_up  output  NUM_FLOORS  pending hall-up bitmap.
- pend_dn  output  NUM_FLOORS  pending hall-down bitmap.
- pend_car  output  NUM_FLOORS  pending car-call bitmap.

Behaviour:
- Reset (async, immediate):
  - pend_up, pend_dn and pend_car = 0.
  - State = IDLE, ev_dir = 00.
  - target_floor = 0, target_valid = 0.
  - Internal door_q = 0.
- Latching: each cycle, pend_x <= (pend_x | x_req) & ~clear_x. Masked bits (up at top floor, down at floor 0) are never set.
- Door event: door_rise = ev_door & ~door_q. door_q is registered every cycle.
- Serving at floor f = ev_floor on door_rise:
  - Always clear pend_car[f].
  - UP: clear pend_up[f]. Also clear pend_dn[f] if no call of any kind exists above f; state then becomes DOWN.
  - DOWN: mirror of UP. Clear pend_dn[f], plus pend_up[f] if nothing exists below f; state then becomes UP.
  - IDLE: clear pend_up[f] and pend_dn[f].
- Same-cycle request and clear of one bit: the request wins only if ev_door is low. A request at the current floor while the door is open is absorbed (not latched).
- "Above" = any pending bit with index > ev_floor; "below" = index < ev_floor. Both are computed from the combined bitmaps.
- Target selection (registered; target_floor/target_valid update 1 cycle after the pending/floor/state change that caused it):
  - UP: lowest floor > ev_floor with car or up call. Else the highest floor > ev_floor with a down call. Else, if a call exists at ev_floor, target = ev_floor.
  - DOWN: mirror of UP (highest floor < ev_floor with car or down call; else lowest floor < ev_floor with an up call).
  - IDLE with calls: go UP if the nearest call is above, DOWN if below. Equal distance selects UP. A call at ev_floor gives target = ev_floor with ev_dir held at 00.
  - No pending calls in any state: state -> IDLE, ev_dir = 00, target_valid = 0, target_floor holds last value.
- State transitions (evaluated each cycle after clearing):
  - UP -> DOWN when nothing is above and something is below.
  - DOWN -> UP symmetrically.
  - UP/DOWN -> IDLE when all bitmaps are 0.
  - No reversal while a qualifying call remains ahead.
- target_floor is never changed while ev_door = 1, except for clearing-driven updates.
- Arithmetic: distance compares use FLOOR_W+1 bits unsigned. No wrap-around; floor indices outside 0..NUM_FLOORS-1 on ev_floor are treated as "no call above/below".
- Reset mid-travel: all calls are discarded and target_valid drops immediately. The motion block holds position; no recovery of lost calls.

Test Plan:
1. Reset, ev_floor=0, pulse car_req[5] → pend_car=0x20; next cycle state UP, ev_dir=01, target_floor=5, target_valid=1.
2. Car at 2 moving UP, pending car 6 and hall_up 4 → target 4. ev_floor=4 with door_rise → pend_up[4] cleared, target 6.
3. UP at floor 3, only hall_dn[1] and hall_dn[6] pending → target 6. At 6 with door_rise → pend_dn[6] cleared, state DOWN, target 1.
4. IDLE at floor 4, simultaneous car_req[2] and car_req[6] → UP chosen (tie), target 6.
5. ev_door=1 at floor 3, assert hall_up_req[3] for 2 cycles → pend_up[3] stays 0; assert hall_up_req[3] after the door closes → pend_up[3]=1.
6. Calls pending at 1, 5, 7 in UP, assert rst asynchronously between clocks → all bitmaps 0, target_valid=0, ev_dir=00 without waiting for clk.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches hall/car calls and runs a collective SCAN policy,
// presenting one registered target floor at a time to the motion/door block.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FLOOR_W-1:0]    ev_floor,
  input  logic                  ev_door,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic [1:0]            ev_dir,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic [NUM_FLOORS-1:0] pend_car
);
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_e;

  function automatic logic [FLOOR_W:0] lowest(input logic [NUM_FLOORS-1:0] v);
    lowest = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (v[i]) lowest = (FLOOR_W+1)'(i);
  endfunction

  function automatic logic [FLOOR_W:0] highest(input logic [NUM_FLOORS-1:0] v);
    highest = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (v[i]) highest = (FLOOR_W+1)'(i);
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pend_up_q, pend_up_d, pend_dn_q, pend_dn_d, pend_car_q, pend_car_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    valid_q, valid_d, door_q;
  logic [NUM_FLOORS-1:0]   here, abv_m, blw_m, cur_all, absorb, p_up, p_dn, p_car, p_all;
  logic                    door_rise, hold, cur_above, cur_below, above, below, at_here, reach;
  logic [FLOOR_W:0]        fz, lo_a, hi_b, tgt;

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here[i]  = i == int'(ev_floor);
      abv_m[i] = i > int'(ev_floor);
      blw_m[i] = i < int'(ev_floor) && int'(ev_floor) < NUM_FLOORS;
    end
    fz = {1'b0, ev_floor};
    door_rise = ev_door & ~door_q;
    hold = ev_door & door_q;
    cur_all = pend_up_q | pend_dn_q | pend_car_q;
    cur_above = |(cur_all & abv_m);
    cur_below = |(cur_all & blw_m);
    // the opposite-direction hall call is served only when the car turns around here
    p_car = door_rise ? pend_car_q & ~here : pend_car_q;
    p_up = door_rise && (state_q != DOWN || !cur_below) ? pend_up_q & ~here : pend_up_q;
    p_dn = door_rise && (state_q != UP || !cur_above) ? pend_dn_q & ~here : pend_dn_q;
    absorb = ev_door ? here : '0;
    pend_up_d = p_up | (hall_up_req & ~absorb & {1'b0, {(NUM_FLOORS-1){1'b1}}});
    pend_dn_d = p_dn | (hall_dn_req & ~absorb & {{(NUM_FLOORS-1){1'b1}}, 1'b0});
    pend_car_d = p_car | (car_req & ~absorb);
    p_all = p_up | p_dn | p_car;
    above = |(p_all & abv_m);
    below = |(p_all & blw_m);
    at_here = |(p_all & here);
    reach = above | below | at_here;
    lo_a = lowest(p_all & abv_m);
    hi_b = highest(p_all & blw_m);
    state_d = !reach ? IDLE :
              state_q == UP ? (above || !below ? UP : DOWN) :
              state_q == DOWN ? (below || !above ? DOWN : UP) :
              at_here ? IDLE :
              above && (!below || lo_a - fz <= fz - hi_b) ? UP : DOWN;
    tgt = state_d == UP ? (|((p_car | p_up) & abv_m) ? lowest((p_car | p_up) & abv_m) :
                           above ? highest(p_dn & abv_m) : fz) :
          state_d == DOWN ? (|((p_car | p_dn) & blw_m) ? highest((p_car | p_dn) & blw_m) :
                             below ? lowest(p_up & blw_m) : fz) : fz;
    target_d = hold || !reach ? target_q : tgt[FLOOR_W-1:0];
    valid_d = reach;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      pend_up_q  <= '0;
      pend_dn_q  <= '0;
      pend_car_q <= '0;
      target_q   <= '0;
      valid_q    <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      pend_car_q <= pend_car_d;
      target_q   <= target_d;
      valid_q    <= valid_d;
      door_q     <= ev_door;
    end

  assign target_floor = target_q;
  assign target_valid = valid_q;
  assign ev_dir       = state_q;
  assign pend_up      = pend_up_q;
  assign pend_dn      = pend_dn_q;
  assign pend_car     = pend_car_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed scenarios plus random traffic checked against
// a floor-by-floor behavioural model of the SCAN scheduler.
module tb_elevator_call_scheduler;
  localparam int N = 8;
  logic         clk = 1'b0, rst;
  logic [N-1:0] hu, hd, cr;
  logic [2:0]   fl;
  logic         door;
  logic [2:0]   tf;
  logic         tv;
  logic [1:0]   dir;
  logic [N-1:0] pu, pd, pc;
  int checks = 0, failures = 0;
  bit mu[N], md[N], mc[N];
  int mdir, mtgt;
  bit mval, mdoor;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.NUM_FLOORS(N), .FLOOR_W(3)) dut (
    .clk(clk), .rst(rst), .hall_up_req(hu), .hall_dn_req(hd), .car_req(cr),
    .ev_floor(fl), .ev_door(door), .target_floor(tf), .target_valid(tv),
    .ev_dir(dir), .pend_up(pu), .pend_dn(pd), .pend_car(pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] vec(input bit a[N]);
    for (int i = 0; i < N; i++) vec[i] = a[i];
  endfunction

  function automatic bit call_at(input int i);
    return mu[i] | md[i] | mc[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mu[i] = 0; md[i] = 0; mc[i] = 0; end
    mdir = 0; mtgt = 0; mval = 0; mdoor = 0;
  endtask

  task automatic model_step();
    int f, nt;
    bit rise, ab, bl, hr, found;
    f = int'(fl);
    rise = door && !mdoor;
    ab = 0; bl = 0;
    for (int i = f + 1; i < N; i++) ab |= call_at(i);
    for (int i = 0; i < f; i++) bl |= call_at(i);
    if (rise) begin
      mc[f] = 0;
      if (mdir == 1) begin mu[f] = 0; if (!ab) md[f] = 0; end
      else if (mdir == 2) begin md[f] = 0; if (!bl) mu[f] = 0; end
      else begin mu[f] = 0; md[f] = 0; end
    end
    ab = 0; bl = 0;
    for (int i = f + 1; i < N; i++) ab |= call_at(i);
    for (int i = 0; i < f; i++) bl |= call_at(i);
    hr = call_at(f);
    if (!ab && !bl && !hr) begin
      mdir = 0; mval = 0;
    end else begin
      if (mdir == 1) mdir = (!ab && bl) ? 2 : 1;
      else if (mdir == 2) mdir = (!bl && ab) ? 1 : 2;
      else if (!hr)
        for (int d = 1; d < N; d++) begin
          if (f + d < N && call_at(f + d)) begin mdir = 1; break; end
          if (f - d >= 0 && call_at(f - d)) begin mdir = 2; break; end
        end
      nt = f; found = 0;
      if (mdir == 1) begin
        for (int i = f + 1; i < N && !found; i++) if (mc[i] || mu[i]) begin nt = i; found = 1; end
        for (int i = N - 1; i > f && !found; i--) if (md[i]) begin nt = i; found = 1; end
      end else if (mdir == 2) begin
        for (int i = f - 1; i >= 0 && !found; i--) if (mc[i] || md[i]) begin nt = i; found = 1; end
        for (int i = 0; i < f && !found; i++) if (mu[i]) begin nt = i; found = 1; end
      end
      mval = 1;
      if (!(door && !rise)) mtgt = nt;
    end
    for (int i = 0; i < N; i++)
      if (!(door && i == f)) begin
        if (hu[i] && i != N - 1) mu[i] = 1;
        if (hd[i] && i != 0) md[i] = 1;
        if (cr[i]) mc[i] = 1;
      end
    mdoor = door;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("pend_up", pu, vec(mu));
    chk("pend_dn", pd, vec(md));
    chk("pend_car", pc, vec(mc));
    chk("ev_dir", dir, mdir);
    chk("target_valid", tv, mval);
    chk("target_floor", tf, mtgt);
  endtask

  task automatic do_reset();
    hu = '0; hd = '0; cr = '0; door = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    rst = 1; hu = '0; hd = '0; cr = '0; fl = 0; door = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend", {pu, pd, pc}, 0);
    chk("rst_dir", dir, 0);
    chk("rst_valid", tv, 0);
    chk("rst_target", tf, 0);
    rst = 0;
    // single car call from floor 0
    cr = 8'h20; cyc();
    chk("t1_car", pc, 8'h20);
    cr = '0; cyc();
    chk("t1_dir", dir, 2'b01);
    chk("t1_tgt", tf, 5);
    chk("t1_valid", tv, 1);
    // car call 6 plus hall up 4 while going up from 2
    do_reset();
    fl = 2; cr = 8'h40; hu = 8'h10; cyc();
    cr = '0; hu = '0; cyc();
    chk("t2_tgt4", tf, 4);
    fl = 4; door = 1; cyc();
    chk("t2_up_clr", pu, 0);
    chk("t2_tgt6", tf, 6);
    door = 0; cyc();
    // down calls only, served at the top then reversing
    do_reset();
    fl = 0; cr = 8'h08; cyc();
    cr = '0; hd = 8'h42; cyc();
    hd = '0; cyc();
    fl = 3; door = 1; cyc();
    chk("t3_dir_up", dir, 2'b01);
    chk("t3_tgt6", tf, 6);
    door = 0; cyc();
    fl = 6; door = 1; cyc();
    chk("t3_dn_clr", pd, 8'h02);
    chk("t3_dir_dn", dir, 2'b10);
    chk("t3_tgt1", tf, 1);
    door = 0; cyc();
    // equidistant calls from idle prefer up
    do_reset();
    fl = 4; cr = 8'h44; cyc();
    cr = '0; cyc();
    chk("t4_dir", dir, 2'b01);
    chk("t4_tgt", tf, 6);
    // request at current floor absorbed while door open
    do_reset();
    fl = 3; door = 1; hu = 8'h08; cyc(); cyc();
    chk("t5_absorb", pu, 0);
    door = 0; cyc();
    chk("t5_latch", pu, 8'h08);
    hu = '0; cyc();
    // asynchronous reset mid-travel
    do_reset();
    fl = 3; cr = 8'hA2; cyc();
    cr = '0; cyc();
    chk("t6_pre_dir", dir, 2'b01);
    #3 rst = 1;
    #1;
    chk("t6_pend", {pu, pd, pc}, 0);
    chk("t6_valid", tv, 0);
    chk("t6_dir", dir, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) fl = 3'($urandom_range(0, N - 1));
      door = $urandom_range(0, 2) == 0;
      hu = $urandom_range(0, 2) == 0 ? N'($urandom & $urandom & $urandom) : '0;
      hd = $urandom_range(0, 2) == 0 ? N'($urandom & $urandom & $urandom) : '0;
      cr = $urandom_range(0, 2) == 0 ? N'($urandom & $urandom & $urandom) : '0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
